and2_vec: RTL and testbench



---
 rtl/and2_vec.sv | 21 ++
 tb/tb_and2_vec.sv | 119 +++++++++++
 2 files changed

// File: rtl/and2_vec.sv
// Registered bitwise AND of two WIDTH-bit operands; one cycle latency.
// The register drives c directly, so there is no combinational path from a/b to c.
module and2_vec #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  always_ff @(posedge clk) begin
    if (reset) begin
      c <= '0;
    end else begin
      c <= a & b;
    end
  end

endmodule

// File: tb/tb_and2_vec.sv
// Directed vector bench for and2_vec: table of per-edge stimulus/expectations
// plus hand-written sequences for the between-edge reset corner.
module tb_and2_vec;

  localparam int unsigned WIDTH = 2;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;

  int unsigned n_cmp;
  int unsigned n_bad;

  typedef struct {
    string            name;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  and2_vec #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .c    (c)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: c=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic rst,
                     input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                     input logic [WIDTH-1:0] vexp);
    vec_t v;
    v.name = name; v.rst = rst; v.a = va; v.b = vb; v.exp = vexp;
    vecs.push_back(v);
  endtask

  initial begin
    logic [WIDTH-1:0] prev;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    a = '0;
    b = '0;

    // Each entry: inputs held across one rising edge, expected c after it.
    for (int i = 0; i < 5; i++) add("reset_hold", 1'b1, 2'b11, 2'b11, 2'b00);
    add("release_zero",  1'b0, 2'b00, 2'b00, 2'b00);
    add("partial_a",     1'b0, 2'b11, 2'b00, 2'b00);
    add("partial_ab",    1'b0, 2'b11, 2'b11, 2'b11);
    for (int r = 0; r < 2; r++) begin
      add("toggle_11_00", 1'b0, 2'b11, 2'b00, 2'b00);
      add("toggle_11_11", 1'b0, 2'b11, 2'b11, 2'b11);
      add("toggle_00_11", 1'b0, 2'b00, 2'b11, 2'b00);
      add("toggle_00_00", 1'b0, 2'b00, 2'b00, 2'b00);
    end
    add("mixed_10_11",   1'b0, 2'b10, 2'b11, 2'b10);
    add("mixed_01_01",   1'b0, 2'b01, 2'b01, 2'b01);
    add("mixed_01_10",   1'b0, 2'b01, 2'b10, 2'b00);
    add("pre_reset_11",  1'b0, 2'b11, 2'b11, 2'b11);
    add("mid_reset",     1'b1, 2'b11, 2'b11, 2'b00);
    add("post_reset_11", 1'b0, 2'b11, 2'b11, 2'b11);

    prev = '0;
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      a     = vecs[i].a;
      b     = vecs[i].b;
      // Inputs just changed: c must still show the previous edge's result.
      #1;
      if (i > 0) check({vecs[i].name, "_hold_before_edge"}, c, prev);
      @(posedge clk);
      #9;
      check(vecs[i].name, c, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Reset pulse entirely between edges must be ignored.
    a = 2'b11; b = 2'b11; reset = 1'b0;
    @(posedge clk); #9;
    check("glitch_pre", c, 2'b11);
    a = 2'b10; b = 2'b11;
    #2 reset = 1'b1;
    #2 check("glitch_during", c, 2'b11);
    #2 reset = 1'b0;
    @(posedge clk); #9;
    check("glitch_ignored", c, 2'b10);

    // Reset held across several edges stays zero, release loads immediately.
    a = 2'b01; b = 2'b11; reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #9;
      check("reset_multi", c, 2'b00);
    end
    reset = 1'b0;
    @(posedge clk); #9;
    check("release_load", c, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
